fios_result_collector: RTL and testbench



---
 rtl/fios_pkg.sv | 12 +
 rtl/fios_result_fifo.sv | 42 ++++
 rtl/fios_result_collector.sv | 59 +++++
 tb/tb_fios_result_collector.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// fios_pkg: shared widths, FSM states and FIFO entry layout for the FIOS result collector.
package fios_pkg;
  localparam int WORD_WIDTH = 17;
  localparam int P_WIDTH = 34;
  localparam int CARRY_WIDTH = 18;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
  typedef struct packed {
    logic last;
    logic ovf;
    logic [WORD_WIDTH-1:0] word;
  } entry_t;
endpackage

// File: rtl/fios_result_fifo.sv
// fios_result_fifo: show-ahead FIFO; push succeeds when full only if a pop happens the same cycle.
module fios_result_fifo
  import fios_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty,
  output logic   drop
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    drop = push && full && !do_pop;
    dout = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fios_result_collector.sv
// fios_result_collector: carry-normalizes DSP P words into 17-bit limbs and buffers them for a ready/valid consumer.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int WORD_COUNT = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  p_valid_i,
  input  logic [P_WIDTH-1:0]    p_i,
  output logic [WORD_WIDTH-1:0] res_word_o,
  output logic                  res_last_o,
  output logic                  res_ovf_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  error_o
);
  localparam int CW = $clog2(WORD_COUNT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [CARRY_WIDTH-1:0] carry;
  logic [P_WIDTH:0] sum;
  logic push, full, empty, drop;
  entry_t din, head;
  always_comb begin
    sum = {1'b0, p_i} + (P_WIDTH+1)'(carry);
    push = state == FLUSH || p_valid_i;
    din = state == FLUSH ? {1'b1, carry[CARRY_WIDTH-1], carry[WORD_WIDTH-1:0]}
                         : {2'b00, sum[WORD_WIDTH-1:0]};
    res_word_o = head.word;
    res_last_o = head.last;
    res_ovf_o = head.ovf;
    res_valid_o = !empty;
  end
  fios_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clock_i), .rst(reset_i), .push(push), .din(din), .pop(res_ready_i),
    .dout(head), .full(full), .empty(empty), .drop(drop)
  );
  // Carry and counter advance even when the FIFO drops, so operand framing survives overflow.
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      carry <= '0;
      error_o <= 1'b0;
    end else begin
      error_o <= error_o | drop | (state == FLUSH && p_valid_i);
      if (state == FLUSH) begin
        state <= IDLE;
        cnt <= '0;
        carry <= '0;
      end else if (p_valid_i) begin
        carry <= sum[P_WIDTH:WORD_WIDTH];
        cnt <= cnt + 1'b1;
        state <= cnt == CW'(WORD_COUNT - 1) ? FLUSH : ACCUM;
      end
    end
endmodule

// File: tb/tb_fios_result_collector.sv
// tb_fios_result_collector: scoreboard bench with a reference carry model and directed limb constants.
module tb_fios_result_collector;
  localparam int WC = 4;
  localparam int DEPTH = 8;
  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  logic p_valid_i = 1'b0;
  logic [33:0] p_i = '0;
  logic [16:0] res_word_o;
  logic res_last_o, res_ovf_o, res_valid_o, error_o;
  logic res_ready_i = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [18:0] q[$];
  logic [18:0] seen[$];
  longint mcarry;
  int mcnt;
  bit mflush;
  bit merr;

  fios_result_collector #(.WORD_COUNT(WC), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .p_valid_i(p_valid_i), .p_i(p_i),
    .res_word_o(res_word_o), .res_last_o(res_last_o), .res_ovf_o(res_ovf_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [33:0] p, input logic rdy);
    logic [18:0] e;
    logic pop, full_before, push;
    longint s;
    @(negedge clock_i);
    p_valid_i = v;
    p_i = p;
    res_ready_i = rdy;
    #1;
    chk("valid", res_valid_o, q.size() != 0);
    full_before = q.size() == DEPTH;
    pop = rdy && q.size() != 0;
    if (pop) begin
      chk("head", {res_last_o, res_ovf_o, res_word_o}, q[0]);
      seen.push_back({res_last_o, res_ovf_o, res_word_o});
      void'(q.pop_front());
    end
    push = 1'b0;
    e = '0;
    if (mflush) begin
      push = 1'b1;
      e = {1'b1, mcarry[17], mcarry[16:0]};
      if (v) merr = 1'b1;
      mcarry = 0;
      mcnt = 0;
      mflush = 1'b0;
    end else if (v) begin
      push = 1'b1;
      s = longint'(p) + mcarry;
      e = {2'b00, s[16:0]};
      mcarry = s >>> 17;
      mcnt++;
      mflush = mcnt == WC;
    end
    if (push) begin
      if (full_before && !pop) merr = 1'b1;
      else q.push_back(e);
    end
    @(posedge clock_i);
    #1;
    chk("error", error_o, merr);
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    reset_i = 1'b1;
    p_valid_i = 1'b0;
    #1;
    chk("rst_valid", res_valid_o, 0);
    chk("rst_word", res_word_o, 0);
    chk("rst_flags", {res_last_o, res_ovf_o}, 0);
    chk("rst_error", error_o, 0);
    q.delete();
    mcarry = 0;
    mcnt = 0;
    mflush = 1'b0;
    merr = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic operand(input logic [33:0] w0, w1, w2, w3, input logic rdy);
    step(1, w0, rdy);
    step(1, w1, rdy);
    step(1, w2, rdy);
    step(1, w3, rdy);
    step(0, 0, rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  initial begin
    logic [18:0] ones_exp[5] = '{19'h1FFFF, 19'h1FFFE, 19'h1FFFF, 19'h1FFFF, 19'h60000};
    logic [18:0] one_exp[5] = '{19'h00001, 19'h00001, 19'h00000, 19'h00000, 19'h40000};
    do_reset();
    seen.delete();
    operand(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 1);
    drain(3);
    chk("ones_n", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("ones_limb", seen[i], ones_exp[i]);
    seen.delete();
    step(1, 34'h20001, 1);
    step(1, 0, 1);
    chk("lat1_word", res_word_o, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    drain(3);
    chk("one_n", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("one_limb", seen[i], one_exp[i]);
    operand(34'h1234_5678, 34'h2_0000_0001, 34'h3_8000_0000, 34'h0_0001_FFFF, 0);
    step(1, 34'h3_0000_0003, 0);
    step(1, 34'h1_FFFF_0000, 0);
    step(1, 34'h2_ABCD_EF01, 0);
    chk("full_q", q.size(), DEPTH);
    step(1, 34'h3_FFFF_FFFF, 1);
    step(0, 0, 1);
    chk("full_pop_err", error_o, 0);
    chk("full_q8", q.size(), DEPTH);
    seen.delete();
    drain(10);
    chk("full_drain", seen.size(), DEPTH);
    for (int i = 0; i < 2; i++) operand(34'h3_FFFF_FFFF, 34'h0_0002_0001, 34'h1_5555_5555, 34'h2_AAAA_AAAA, 0);
    chk("ovf_err", error_o, 1);
    seen.delete();
    drain(10);
    chk("ovf_drain", seen.size(), DEPTH);
    do_reset();
    step(1, 34'h3_FFFF_FFFF, 1);
    step(1, 34'h3_FFFF_FFFF, 1);
    step(1, 34'h3_FFFF_FFFF, 1);
    step(1, 34'h3_FFFF_FFFF, 1);
    step(1, 34'h0_0000_0007, 1);
    chk("flush_err", error_o, 1);
    operand(34'h9, 0, 0, 0, 1);
    drain(3);
    step(1, 34'h3_FFFF_FFFF, 1);
    step(1, 34'h3_FFFF_FFFF, 1);
    do_reset();
    seen.delete();
    operand(5, 0, 0, 0, 1);
    drain(3);
    chk("rst_op_n", seen.size(), 5);
    if (seen.size() == 5) begin
      chk("rst_op_l0", seen[0], 19'h00005);
      chk("rst_op_l4", seen[4], 19'h40000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
